// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package nibble_add_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nnib(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_add_seq.sv
// Drives an external combinational 4-bit adder one nibble per clock, LSB first,
// threading the carry through a register and assembling a WIDTH-bit result.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [3:0]       fa_A,
    output logic [3:0]       fa_B,
    output logic             fa_Cin,
    input  logic [3:0]       fa_Z,
    input  logic             fa_Cout
);

    localparam int NNIB = calc_nnib(WIDTH);
    localparam int IDXW = $clog2(NNIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new start is taken in IDLE and also in DONE, which allows back-to-back sequences.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            a_reg <= A_in;
            b_reg <= B_in;
            carry <= Cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[NIB_W*idx +: NIB_W] <= fa_Z;
            carry                     <= fa_Cout;
            if (idx == LAST_IDX) begin
                cout_r <= fa_Cout;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    assign fa_A   = a_reg[NIB_W*idx +: NIB_W];
    assign fa_B   = b_reg[NIB_W*idx +: NIB_W];
    assign fa_Cin = carry;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign Sum    = sum_r;
    assign Cout   = cout_r;

endmodule
